// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences one N x N matrix multiply into a systolic array.
// Operands are latched on an accepted start, then skewed onto the west (rows of A)
// and north (columns of B) edges over 3N-2 feed cycles, the last N-1 of which
// are zero to drain the array.
// Packing: a_i/b_i element (i,j) lives at bits [(i*N+j)*NUM_BITS +: NUM_BITS];
// west_o/north_o lane i lives at bits [i*NUM_BITS +: NUM_BITS].
// Optional build macro SYSTOLIC_ACC_EN adds acc_i, which skips CLEAR so results
// accumulate onto the previous C.
module systolic_feed_ctrl #(
  parameter int N        = 4,
  parameter int NUM_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
`ifdef SYSTOLIC_ACC_EN
  input  logic                       acc_i,
`endif
  input  logic [N*N*NUM_BITS-1:0]    a_i,
  input  logic [N*N*NUM_BITS-1:0]    b_i,
  output logic [N*NUM_BITS-1:0]      west_o,
  output logic [N*NUM_BITS-1:0]      north_o,
  output logic                       pe_clr_o,
  output logic                       pe_en_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       c_valid_o
);

  localparam int FEED_CYCLES = 3 * N - 2;
  localparam int CW          = (FEED_CYCLES > 1) ? $clog2(FEED_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(FEED_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [CW-1:0]             cnt_reg;
  logic [N*N*NUM_BITS-1:0]   a_buf_reg, b_buf_reg;
  logic                      c_valid_reg;
  logic                      accept;
  int                        k_int;

  // A start counts only in IDLE and never in a reset cycle.
  assign accept = (state_reg == IDLE) && start_i && !rst;
  assign k_int  = int'(cnt_reg);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_next = state_reg;
    pe_clr_o   = 1'b0;
    pe_en_o    = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
`ifdef SYSTOLIC_ACC_EN
          state_next = acc_i ? FEED : CLEAR;
`else
          state_next = CLEAR;
`endif
        end
      end
      CLEAR: begin
        pe_clr_o   = 1'b1;
        state_next = FEED;
      end
      FEED: begin
        pe_en_o = 1'b1;
        if (cnt_reg == LAST_K) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Feed step counter k; sits at 0 outside FEED and stops at the last step.
  always_ff @(posedge clk) begin
    if (rst)                                     cnt_reg <= '0;
    else if (state_reg == FEED && cnt_reg != LAST_K) cnt_reg <= cnt_reg + 1'b1;
    else                                         cnt_reg <= '0;
  end

  // Operand buffers, loaded only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_buf_reg <= '0;
      b_buf_reg <= '0;
    end else if (state_reg == IDLE && start_i) begin
      a_buf_reg <= a_i;
      b_buf_reg <= b_i;
    end
  end

  // Result-valid flag: set entering DONE, cleared when the next start is taken.
  always_ff @(posedge clk) begin
    if (rst)                                      c_valid_reg <= 1'b0;
    else if (accept)                              c_valid_reg <= 1'b0;
    else if (state_reg == FEED && cnt_reg == LAST_K) c_valid_reg <= 1'b1;
  end

  // The old result stops being valid in the very cycle a new start is taken.
  assign c_valid_o = c_valid_reg && !accept;

  // Skewed edge feed: lane gi carries A[gi][k-gi] west and B[k-gi][gi] north.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_edge
      logic in_win;
      int   a_idx;
      int   b_idx;
      assign in_win = (state_reg == FEED) && (k_int >= gi) && (k_int < gi + N);
      assign a_idx  = in_win ? (gi * N + (k_int - gi)) : 0;
      assign b_idx  = in_win ? ((k_int - gi) * N + gi) : 0;
      assign west_o[gi*NUM_BITS +: NUM_BITS]  =
        in_win ? a_buf_reg[a_idx*NUM_BITS +: NUM_BITS] : '0;
      assign north_o[gi*NUM_BITS +: NUM_BITS] =
        in_win ? b_buf_reg[b_idx*NUM_BITS +: NUM_BITS] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl (default build). The reference model tracks each
// accepted operation as a cycle offset from its start and derives the expected
// edge operands from the matrix indices; a behavioural PE grid fed by the DUT
// outputs must end each operation holding the plain matrix product A*B.
module tb_systolic_feed_ctrl;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 3 * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start_i, acc_i;
  logic [N*N*W-1:0] a_i, b_i;
  logic [N*W-1:0]   west_o, north_o;
  logic             pe_clr_o, pe_en_o, busy_o, done_o, c_valid_o;

  systolic_feed_ctrl #(.N(N), .NUM_BITS(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
`ifdef SYSTOLIC_ACC_EN
    .acc_i(acc_i),
`endif
    .a_i(a_i), .b_i(b_i), .west_o(west_o), .north_o(north_o),
    .pe_clr_o(pe_clr_o), .pe_en_o(pe_en_o), .busy_o(busy_o),
    .done_o(done_o), .c_valid_o(c_valid_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ma[N][N], mb[N][N];   // matrices currently driven
  int ea[N][N], eb[N][N];   // matrices of the operation in progress
  int ph = -1;              // cycles since acceptance, -1 when idle
  bit cv = 1'b0;            // result-valid
  int pacc[N][N], pa[N][N], pb[N][N], na[N][N], nb[N][N];
  int done_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_i[(i*N+j)*W +: W] = W'(ma[i][j]);
        b_i[(i*N+j)*W +: W] = W'(mb[i][j]);
      end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = int'($urandom_range(0, 255));
        mb[i][j] = int'($urandom_range(0, 255));
      end
    drive_mats();
  endtask

  task automatic check_cycle();
    bit en_e;
    int k, we, ne, sum;
    en_e = (ph >= 2) && (ph <= LAT - 1);
    k    = ph - 2;
    chk("busy", 32'(busy_o), 32'(ph != -1));
    chk("pe_clr", 32'(pe_clr_o), 32'(ph == 1));
    chk("pe_en", 32'(pe_en_o), 32'(en_e));
    chk("done", 32'(done_o), 32'(ph == LAT));
    chk("c_valid", 32'(c_valid_o), 32'((ph == -1) ? (cv && !(start_i && !rst)) : cv));
    for (int i = 0; i < N; i++) begin
      we = (en_e && k - i >= 0 && k - i < N) ? ea[i][k-i] : 0;
      ne = (en_e && k - i >= 0 && k - i < N) ? eb[k-i][i] : 0;
      chk($sformatf("west%0d_c%0d", i, cyc), 32'(west_o[i*W +: W]), 32'(we));
      chk($sformatf("north%0d_c%0d", i, cyc), 32'(north_o[i*W +: W]), 32'(ne));
    end
    if (ph == LAT) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          sum = 0;
          for (int m = 0; m < N; m++) sum += ea[i][m] * eb[m][j];
          chk($sformatf("C%0d%0d", i, j), 32'(pacc[i][j]), 32'(sum));
        end
    end
    if (done_o === 1'b1) done_q.push_back(cyc);
  endtask

  task automatic model_edge();
    int ain, bin;
    // behavioural PE grid absorbing this cycle's feed
    if (pe_clr_o === 1'b1) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pacc[i][j] = 0; pa[i][j] = 0; pb[i][j] = 0;
        end
    end else if (pe_en_o === 1'b1) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ain = (j == 0) ? int'(west_o[i*W +: W]) : pa[i][j-1];
          bin = (i == 0) ? int'(north_o[j*W +: W]) : pb[i-1][j];
          pacc[i][j] += ain * bin;
          na[i][j] = ain; nb[i][j] = bin;
        end
      pa = na; pb = nb;
    end
    // operation timeline
    if (rst) begin
      ph = -1; cv = 1'b0;
    end else if (ph == -1) begin
      if (start_i) begin
        ph = 1; cv = 1'b0; ea = ma; eb = mb;
      end
    end else begin
      ph++;
      if (ph == LAT) cv = 1'b1;
      else if (ph > LAT) ph = -1;
    end
  endtask

  task automatic step(input bit st, input bit r);
    start_i = st; rst = r;
    #1;
    check_cycle();
    model_edge();
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int c0;
    acc_i = 1'b0; start_i = 1'b0; rst = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0; mb[i][j] = 0; ea[i][j] = 0; eb[i][j] = 0;
        pacc[i][j] = 0; pa[i][j] = 0; pb[i][j] = 0;
      end
    drive_mats();
    repeat (2) @(posedge clk);
    #1;

    // reset state
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // identity x identity
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0; mb[i][j] = (i == j) ? 1 : 0;
      end
    drive_mats();
    done_q.delete(); c0 = cyc;
    step(1'b1, 1'b0);
    repeat (LAT + 2) step(1'b0, 1'b0);
    chk("id_done_n", 32'(done_q.size()), 32'd1);
    chk("id_done_at", 32'(done_q.size() > 0 ? done_q[0] : -1), 32'(c0 + LAT));

    // A[i][j]=i*4+j+1, B all 2
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = i * 4 + j + 1; mb[i][j] = 2;
      end
    drive_mats();
    step(1'b1, 1'b0);
    repeat (LAT + 1) step(1'b0, 1'b0);
    chk("c_row0", 32'(pacc[0][0]), 32'd20);
    chk("c_row3", 32'(pacc[3][2]), 32'd116);

    // start pulse and operand change mid-FEED are ignored
    rand_mats();
    done_q.delete(); c0 = cyc;
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    rand_mats();
    step(1'b1, 1'b0);
    repeat (LAT) step(1'b0, 1'b0);
    chk("busy_start_done_n", 32'(done_q.size()), 32'd1);
    chk("busy_start_done_at", 32'(done_q.size() > 0 ? done_q[0] : -1), 32'(c0 + LAT));

    // reset at FEED k=3 aborts, then a fresh run completes
    rand_mats();
    done_q.delete();
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    chk("abort_no_done", 32'(done_q.size()), 32'd0);
    c0 = cyc;
    step(1'b1, 1'b0);
    repeat (LAT + 1) step(1'b0, 1'b0);
    chk("after_abort_done_at", 32'(done_q.size() > 0 ? done_q[0] : -1), 32'(c0 + LAT));

    // start held high: back-to-back operations
    rand_mats();
    done_q.delete(); c0 = cyc;
    repeat (2 * LAT + 3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("b2b_done0", 32'(done_q.size() > 0 ? done_q[0] : -1), 32'(c0 + LAT));
    chk("b2b_done1", 32'(done_q.size() > 1 ? done_q[1] : -1), 32'(c0 + 2 * LAT + 1));
    repeat (LAT) step(1'b0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) rand_mats();
      step($urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0);
    end
    repeat (LAT + 2) step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
